// File: rtl/md_ctrl.sv
// md_ctrl: E-stage multiply/divide controller for the pipelined MIPS core.
//
// Decodes SPECIAL-opcode MD instructions, owns the HI/LO registers and runs
// a fixed-latency busy window for mult/multu/div/divu.  The result is
// computed at the start edge into pending registers and only committed to
// HI/LO at the final edge of the busy window.
//
// Handshake: there is no valid/ready pair; an E-stage op is accepted
// (start=1) when valid_e is high, the op is mult/multu/div/divu and the unit
// is IDLE.  Upstream must honour stall_req so that no MD instruction reaches
// E while busy; any that do are ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   valid_e    in   E-stage instruction is real
//   instr_e    in   E-stage instruction word
//   rs_e/rt_e  in   forwarded operands, E stage
//   instr_d    in   D-stage instruction word (stall decision only)
//   start      out  mult/div accepted this cycle (combinational)
//   busy       out  operation in flight (from state register)
//   stall_req  out  freeze D/F, bubble into E (combinational)
//   hi/lo      out  HI/LO registers
//   md_rdata   out  hi for mfhi, lo for mflo, else 0 (combinational)
//   state_dbg  out  current FSM state (0=IDLE, 1=BUSY)
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_e,
  input  logic [31:0] instr_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic [31:0] instr_d,
  output logic        start,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata,
  output logic        state_dbg
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  // Only opcode and funct participate in decode.
  logic unused_fields;
  assign unused_fields = ^{instr_e[25:6], instr_d[25:6]};

  logic       special_e, special_d;
  logic [5:0] funct_e, funct_d;
  assign special_e = (instr_e[31:26] == 6'd0);
  assign special_d = (instr_d[31:26] == 6'd0);
  assign funct_e   = instr_e[5:0];
  assign funct_d   = instr_d[5:0];

  logic is_muldiv_e, is_mthi_e, is_mtlo_e, is_mfhi_e, is_mflo_e, md_d;
  assign is_muldiv_e = special_e && (funct_e inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign is_mthi_e   = special_e && (funct_e == F_MTHI);
  assign is_mtlo_e   = special_e && (funct_e == F_MTLO);
  assign is_mfhi_e   = special_e && (funct_e == F_MFHI);
  assign is_mflo_e   = special_e && (funct_e == F_MFLO);
  assign md_d        = special_d && (funct_d inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                                     F_MULT, F_MULTU, F_DIV, F_DIVU});

  // Arithmetic datapath.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{rs_e[31]}}, rs_e}) * $signed({{32{rt_e[31]}}, rt_e});
  assign prod_u = {32'd0, rs_e} * {32'd0, rt_e};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend.  0x80000000 / -1 falls out as 0x80000000, rem 0.
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg = rs_e[31];
  assign b_neg = rt_e[31];
  assign abs_a = a_neg ? (~rs_e + 32'd1) : rs_e;
  assign abs_b = b_neg ? (~rt_e + 32'd1) : rt_e;
  // Divisor forced non-zero so the divider never sees 0; result is discarded.
  assign div_b = (rt_e == 32'd0) ? 32'd1 : rt_e;
  assign q_mag = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign r_mag = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 32'd1) : r_mag;
  assign q_u   = rs_e / div_b;
  assign r_u   = rs_e % div_b;

  assign start = valid_e && (state_q == IDLE) && is_muldiv_e;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = BUSY;
          pend_we_d = 1'b1;
          case (funct_e)
            F_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              cnt_d = CW'(MULT_CYCLES);
            end
            F_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d = CW'(MULT_CYCLES);
            end
            F_DIV: begin
              pend_hi_d = r_s;
              pend_lo_d = q_s;
              pend_we_d = (rt_e != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
            end
            default: begin
              pend_hi_d = r_u;
              pend_lo_d = q_u;
              pend_we_d = (rt_e != 32'd0);
              cnt_d     = CW'(DIV_CYCLES);
            end
          endcase
        end else if (valid_e && is_mthi_e) begin
          hi_d = rs_e;
        end else if (valid_e && is_mtlo_e) begin
          lo_d = rs_e;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign stall_req = md_d && (start || busy);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign md_rdata  = is_mfhi_e ? hi_q : (is_mflo_e ? lo_q : 32'd0);
  assign state_dbg = state_q;

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multi-cycle multiply/divide controller for the E stage of the pipelined MIPS core.
- Decodes SPECIAL-opcode MD instructions from the E-stage instruction word and owns the HI/LO registers.
- Sequences a fixed-latency busy window for mult/div.
- Raises a stall request when the D-stage instruction needs the MD unit while it is occupied.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_e  in  1  E-stage instruction is real (0 = bubble/flushed).
- instr_e  in  32  E-stage instruction word.
- rs_e  in  32  forwarded rs operand, E stage.
- rt_e  in  32  forwarded rt operand, E stage.
- instr_d  in  32  D-stage instruction word (stall decision only).
- start  out  1  combinational; mult/multu/div/divu accepted this cycle.
- busy  out  1  registered; operation in flight.
- stall_req  out  1  combinational; freeze D/F, insert bubble into E.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_rdata  out  32  combinational; hi for mfhi, lo for mflo, else 0.

Behaviour:
- Decode: an instruction is MD only if opcode[31:26]==0. Then funct[5:0] selects:
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
  - 0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
  - Any other word is non-MD.
- Reset (async assert, any time): state IDLE, busy=0, counter=0, hi=0, lo=0, pending results=0. Any operation in flight is discarded.
- FSM IDLE:
  - start = valid_e & state==IDLE & instr_e is mult/multu/div/divu.
  - On start, at the clock edge:
    - compute result into pending HI/LO regs;
    - load counter with MULT_CYCLES or DIV_CYCLES;
    - go to BUSY.
  - mthi/mtlo with valid_e: hi<=rs_e or lo<=rs_e at the edge. Single cycle, no busy.
- FSM BUSY:
  - busy=1. Counter decrements each edge.
  - At the edge where counter==1: hi/lo <= pending, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles after the start cycle; new hi/lo are visible in the first IDLE cycle.
- MD instructions in E while BUSY (mult/div/mt*/mf*) are ignored: no state change, no hi/lo write. Upstream stall guarantees they never occur.
- Arithmetic:
  - mult: signed 32x32 -> 64; multu: unsigned 32x32 -> 64. HI = [63:32], LO = [31:0].
  - div/divu: LO = quotient, HI = remainder. Signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero: full busy window runs, hi/lo keep their prior values.
- stall_req = md_d & (start | busy), where md_d = instr_d is any of the 8 MD instructions.
  - Non-MD instructions in D never stall.
  - A D-stage MD instruction stalls through the start cycle and all busy cycles.
  - stall_req drops in the first IDLE cycle.
- md_rdata is purely combinational from the current hi/lo. A same-cycle write is seen the next cycle.
- valid_e=0 suppresses start and mt* writes regardless of instr_e.

Test Plan:
- Reset, then mult with rs_e=0xFFFFFFFD (-3), rt_e=5 -> start=1 for 1 cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu with 0xFFFFFFFF × 2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- div with rs_e=0xFFFFFFF9 (-7), rt_e=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu 7/2 -> lo=3, hi=1.
- div by zero after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; hi=0x1234 and lo=0x5678 unchanged.
- mult in E with mflo in D -> stall_req=1 on the start cycle plus 5 busy cycles; 0 after. Same scenario with addu in D -> stall_req=0 throughout.
- div started, reset asserted low at busy cycle 4 -> busy, hi, lo all 0 immediately (async). After release, mfhi gives md_rdata=0 and no late hi/lo update.
